// File: rtl/ring_anim_sequencer.sv
// Ring animation sequencer: per-frame phase offset with manual direction or auto run/hold cycling.
// Optional feature: define RING_PALETTE_EN to step palette_sel on every auto RUN->HOLD transition.
module ring_anim_sequencer #(
    parameter int unsigned RUN_FRAMES  = 240,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       speed,
    input  logic       dir_manual,
    input  logic       auto_en,
    input  logic       pause,
    output logic [7:0] anim_offset,
    output logic       direction,
    output logic [1:0] state,
    output logic       seg_done,
    output logic [1:0] palette_sel
);

    typedef enum logic [1:0] {
        OUT_RUN  = 2'd0,
        OUT_HOLD = 2'd1,
        IN_RUN   = 2'd2,
        IN_HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] RUN_LAST  = 8'(RUN_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    state_t     cur_q;
    state_t     next_state;
    logic [7:0] offset_q;
    logic [7:0] frame_cnt;
    logic       seg_done_q;
    logic [7:0] step;
    logic [7:0] moved_offset;
    logic       seg_last;
    logic       accept;

    assign accept = frame_start && !pause;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        step         = speed ? 8'd2 : 8'd1;
        moved_offset = offset_q;
        next_state   = cur_q;
        case (cur_q)
            OUT_RUN:  moved_offset = offset_q + step;
            IN_RUN:   moved_offset = offset_q - step;
            default:  moved_offset = offset_q;
        endcase
        case (cur_q)
            OUT_RUN:  next_state = OUT_HOLD;
            OUT_HOLD: next_state = IN_RUN;
            IN_RUN:   next_state = IN_HOLD;
            default:  next_state = OUT_RUN;
        endcase
        // HOLD states have bit 0 set; each segment length is compared against its own limit.
        seg_last = cur_q[0] ? (frame_cnt == HOLD_LAST) : (frame_cnt == RUN_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q      <= OUT_RUN;
            offset_q   <= 8'd0;
            frame_cnt  <= 8'd0;
            seg_done_q <= 1'b0;
        end else begin
            seg_done_q <= 1'b0;
            if (accept) begin
                // The offset always moves according to the state held before this frame's update.
                offset_q <= moved_offset;
                if (!auto_en) begin
                    cur_q     <= dir_manual ? IN_RUN : OUT_RUN;
                    frame_cnt <= 8'd0;
                end else if (seg_last) begin
                    cur_q      <= next_state;
                    frame_cnt  <= 8'd0;
                    seg_done_q <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

`ifdef RING_PALETTE_EN
    logic [1:0] palette_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            palette_q <= 2'd0;
        end else if (accept && auto_en && seg_last && !cur_q[0]) begin
            palette_q <= palette_q + 2'd1;
        end
    end

    assign palette_sel = palette_q;
`else
    assign palette_sel = 2'd0;
`endif

    assign anim_offset = offset_q;
    assign state       = cur_q;
    assign direction   = cur_q[1];
    assign seg_done    = seg_done_q;

endmodule

// File: tb/tb_ring_anim_sequencer.sv
// Self-checking bench for ring_anim_sequencer: cycle-position reference model plus directed literal checks.
// Build with RING_PALETTE_EN defined to check the palette feature.
module tb_ring_anim_sequencer;

    localparam int R = 4;
    localparam int H = 2;
    localparam int L = 2 * (R + H);

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       speed;
    logic       dir_manual;
    logic       auto_en;
    logic       pause;
    logic [7:0] anim_offset;
    logic       direction;
    logic [1:0] state;
    logic       seg_done;
    logic [1:0] palette_sel;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 0;

    // Model: position inside the full auto cycle, offset as plain integer arithmetic.
    int m_pos = 0;
    int m_off = 0;
    int m_pal = 0;
    int m_seg = 0;

    ring_anim_sequencer #(.RUN_FRAMES(R), .HOLD_FRAMES(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .speed       (speed),
        .dir_manual  (dir_manual),
        .auto_en     (auto_en),
        .pause       (pause),
        .anim_offset (anim_offset),
        .direction   (direction),
        .state       (state),
        .seg_done    (seg_done),
        .palette_sel (palette_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int seg_of(input int p);
        if (p < R)         return 0;
        if (p < R + H)     return 1;
        if (p < 2 * R + H) return 2;
        return 3;
    endfunction

    function automatic int exp_pal();
`ifdef RING_PALETTE_EN
        return m_pal;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) begin
        int old_seg;
        int new_pos;
        int stp;
        if (reset) begin
            m_pos = 0; m_off = 0; m_pal = 0; m_seg = 0;
        end else begin
            m_seg = 0;
            if (frame_start && !pause) begin
                old_seg = seg_of(m_pos);
                stp = speed ? 2 : 1;
                if (old_seg == 0) m_off = (m_off + stp) % 256;
                else if (old_seg == 2) m_off = (m_off + 256 - stp) % 256;
                if (!auto_en) begin
                    m_pos = dir_manual ? (R + H) : 0;
                end else begin
                    new_pos = (m_pos + 1) % L;
                    if (seg_of(new_pos) != old_seg) begin
                        m_seg = 1;
                        if (old_seg == 0 || old_seg == 2) m_pal = (m_pal + 1) % 4;
                    end
                    m_pos = new_pos;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_offset",    int'(anim_offset), m_off);
            check("cyc_state",     int'(state),       seg_of(m_pos));
            check("cyc_direction", int'(direction),   seg_of(m_pos) / 2);
            check("cyc_seg_done",  int'(seg_done),    m_seg);
            check("cyc_palette",   int'(palette_sel), exp_pal());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; speed = 1'b0; dir_manual = 1'b0;
        auto_en = 1'b0; pause = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_en = 1'b1;

        check("reset_offset",  int'(anim_offset), 0);
        check("reset_state",   int'(state), 0);
        check("reset_seg",     int'(seg_done), 0);
        check("reset_palette", int'(palette_sel), 0);

        // Manual outward, step 1
        for (int i = 0; i < 3; i++) begin
            pulse(1);
            check("man_out_seg", int'(seg_done), 0);
        end
        check("man_out_offset", int'(anim_offset), 3);
        check("man_out_state",  int'(state), 0);

        // Manual inward, step 2: first pulse still uses OUT_RUN
        do_reset();
        dir_manual = 1'b1; speed = 1'b1;
        pulse(1);
        check("man_in_first", int'(anim_offset), 8'h02);
        pulse(1);
        check("man_in_second", int'(anim_offset), 8'h00);
        pulse(1);
        check("man_in_third", int'(anim_offset), 8'hFE);
        check("man_in_state", int'(state), 2);
        check("man_in_dir",   int'(direction), 1);

        // Auto full cycle, step 1
        do_reset();
        dir_manual = 1'b0; speed = 1'b0; auto_en = 1'b1;
        pulse(3);
        check("auto_pre_seg", int'(seg_done), 0);
        pulse(1);
        check("auto_s1_state", int'(state), 1);
        check("auto_s1_off",   int'(anim_offset), 4);
        check("auto_s1_seg",   int'(seg_done), 1);
        @(negedge clk);
        check("auto_seg_1cyc", int'(seg_done), 0);
        pulse(2);
        check("auto_s2_state", int'(state), 2);
        check("auto_s2_off",   int'(anim_offset), 4);
        pulse(4);
        check("auto_s3_state", int'(state), 3);
        check("auto_s3_off",   int'(anim_offset), 0);
        pulse(2);
        check("auto_s0_state", int'(state), 0);

        // Pause mid-run
        do_reset();
        pulse(2);
        pause = 1'b1;
        pulse(5);
        check("pause_off",   int'(anim_offset), 2);
        check("pause_state", int'(state), 0);
        pause = 1'b0;
        pulse(2);
        check("pause_resume_state", int'(state), 1);

        // Reset beats a coincident frame_start in IN_RUN at 0x10
        do_reset();
        auto_en = 1'b0; speed = 1'b1; dir_manual = 1'b0;
        pulse(7);
        dir_manual = 1'b1;
        pulse(1);
        check("pre_rst_off",   int'(anim_offset), 8'h10);
        check("pre_rst_state", int'(state), 2);
        @(negedge clk);
        reset = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        reset = 1'b0; frame_start = 1'b0;
        check("rst_prio_off",   int'(anim_offset), 0);
        check("rst_prio_state", int'(state), 0);
        check("rst_prio_dir",   int'(direction), 0);

        // Palette over 12 auto pulses
        do_reset();
        auto_en = 1'b1; speed = 1'b0; dir_manual = 1'b0;
        pulse(12);
`ifdef RING_PALETTE_EN
        check("palette_12", int'(palette_sel), 2);
`else
        check("palette_12", int'(palette_sel), 0);
`endif

        // Randomized traffic; auto_en only toggles on an accepted pulse
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 99) < 2);
            frame_start = ($urandom_range(0, 2) == 0);
            pause       = ($urandom_range(0, 7) == 0);
            speed       = 1'($urandom_range(0, 1));
            dir_manual  = 1'($urandom_range(0, 1));
            if (frame_start && !pause && !reset && $urandom_range(0, 9) == 0)
                auto_en = ~auto_en;
        end
        @(negedge clk);
        reset = 1'b0; frame_start = 1'b0; pause = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
